// File: rtl/alsu_pipe.sv
// Two-stage arithmetic/logic/shift unit with valid/ready handshakes on both sides.
// Stage 1 registers the operand bundle; stage 2 computes and holds the result, error state and LED blink.
module alsu_pipe #(
   parameter int    WIDTH          = 3,
   parameter bit    FULL_ADDER     = 1'b1,
   parameter string INPUT_PRIORITY = "A",
   parameter int    LED_W          = 16,
   parameter int    ERR_CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       A,
   input  logic [WIDTH-1:0]       B,
   input  logic [2:0]             opcode,
   input  logic                   cin,
   input  logic                   serial_in,
   input  logic                   direction,
   input  logic                   red_op_A,
   input  logic                   red_op_B,
   input  logic                   bypass_A,
   input  logic                   bypass_B,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WIDTH-1:0]     out,
   output logic                   err,
   output logic [ERR_CNT_W-1:0]   err_cnt,
   output logic [LED_W-1:0]       leds
);

   localparam int OW    = 2 * WIDTH;
   localparam bit PRI_B = (INPUT_PRIORITY == "B");

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_XOR = 3'b001,
      OP_ADD = 3'b010,
      OP_MUL = 3'b011,
      OP_SHF = 3'b100,
      OP_ROT = 3'b101
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic             cin;
      logic             sin;
      logic             dir;
      logic             ra;
      logic             rb;
      logic             ba;
      logic             bb;
   } bundle_t;

   bundle_t          s1;
   logic             s1_valid;
   logic             adv;
   logic             load;
   logic             invalid;
   logic             use_b;
   logic             red_b;
   logic [OW-1:0]    res;
   logic [WIDTH:0]   sum;
   logic [OW-1:0]    prod;

   assign adv      = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv;
   assign load     = s1_valid && adv;

   // ---------------- stage 1: operand capture ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1       <= '0;
         s1_valid <= 1'b0;
      end else begin
         if (in_ready)
            s1_valid <= in_valid;
         if (in_valid && in_ready)
            s1 <= '{a: A, b: B, op: opcode, cin: cin, sin: serial_in, dir: direction,
                    ra: red_op_A, rb: red_op_B, ba: bypass_A, bb: bypass_B};
      end
   end

   // ---------------- result selection ----------------
   // When both A and B variants are asserted, the B operand wins only under B priority.
   assign use_b = s1.bb && (!s1.ba || PRI_B);
   assign red_b = s1.rb && (!s1.ra || PRI_B);
   assign sum   = {1'b0, s1.a} + {1'b0, s1.b} + {{WIDTH{1'b0}}, FULL_ADDER & s1.cin};
   assign prod  = {{WIDTH{1'b0}}, s1.a} * {{WIDTH{1'b0}}, s1.b};

   always_comb begin
      invalid = 1'b0;
      res     = '0;
      if (s1.op == 3'b110 || s1.op == 3'b111 ||
          ((s1.ra || s1.rb) && s1.op != OP_AND && s1.op != OP_XOR)) begin
         invalid = 1'b1;
      end else if (s1.ba || s1.bb) begin
         res = {{WIDTH{1'b0}}, (use_b ? s1.b : s1.a)};
      end else begin
         case (s1.op)
            OP_AND: begin
               if (s1.ra || s1.rb)
                  res = {{(OW-1){1'b0}}, (red_b ? &s1.b : &s1.a)};
               else
                  res = {{WIDTH{1'b0}}, s1.a & s1.b};
            end
            OP_XOR: begin
               if (s1.ra || s1.rb)
                  res = {{(OW-1){1'b0}}, (red_b ? ^s1.b : ^s1.a)};
               else
                  res = {{WIDTH{1'b0}}, s1.a ^ s1.b};
            end
            OP_ADD: res = {{(WIDTH-1){1'b0}}, sum};
            OP_MUL: res = prod;
            // Shift/rotate act on the held result, whether or not it was consumed.
            OP_SHF: res = s1.dir ? {out[OW-2:0], s1.sin} : {s1.sin, out[OW-1:1]};
            OP_ROT: res = s1.dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
            default: res = '0;
         endcase
      end
   end

   // ---------------- stage 2: result, error tracking, blink ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
         leds      <= '0;
      end else begin
         if (load) begin
            out       <= invalid ? '0 : res;
            out_valid <= 1'b1;
            err       <= invalid;
            if (invalid && err_cnt != '1)
               err_cnt <= err_cnt + ERR_CNT_W'(1);
         end else if (adv) begin
            out_valid <= 1'b0;
         end
         // Blink runs off the registered flag; a valid load clears it to dark.
         if (err)
            leds <= (load && !invalid) ? '0 : ~leds;
      end
   end

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboarded bench for alsu_pipe: a default 3-bit instance and an 8-bit,
// B-priority, half-adder, 2-bit-counter instance sharing clock and reset.
module tb_alsu_pipe;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] CIN  = 7'b1000000;
   localparam logic [6:0] SIN  = 7'b0100000;
   localparam logic [6:0] LEFT = 7'b0010000;
   localparam logic [6:0] RA   = 7'b0001000;
   localparam logic [6:0] RB   = 7'b0000100;
   localparam logic [6:0] BA   = 7'b0000010;
   localparam logic [6:0] BB   = 7'b0000001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance 0: WIDTH=3 defaults
   logic        in_valid0, in_ready0, out_valid0, out_ready0, err0;
   logic [2:0]  a0, b0, op0;
   logic [6:0]  ctl0;
   logic [5:0]  out0;
   logic [7:0]  err_cnt0;
   logic [15:0] leds0;
   logic [6:0]  q0[$];

   // instance 1: WIDTH=8, B priority, no carry-in, 2-bit error counter
   logic        in_valid1, in_ready1, out_valid1, out_ready1, err1;
   logic [7:0]  a1, b1;
   logic [2:0]  op1;
   logic [6:0]  ctl1;
   logic [15:0] out1;
   logic [1:0]  err_cnt1;
   logic [15:0] leds1;
   logic [16:0] q1[$];

   alsu_pipe dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .A(a0), .B(b0), .opcode(op0), .cin(ctl0[6]), .serial_in(ctl0[5]),
      .direction(ctl0[4]), .red_op_A(ctl0[3]), .red_op_B(ctl0[2]),
      .bypass_A(ctl0[1]), .bypass_B(ctl0[0]), .out_valid(out_valid0),
      .out_ready(out_ready0), .out(out0), .err(err0), .err_cnt(err_cnt0), .leds(leds0));

   alsu_pipe #(.WIDTH(8), .FULL_ADDER(1'b0), .INPUT_PRIORITY("B"), .LED_W(16), .ERR_CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .A(a1), .B(b1), .opcode(op1), .cin(ctl1[6]), .serial_in(ctl1[5]),
      .direction(ctl1[4]), .red_op_A(ctl1[3]), .red_op_B(ctl1[2]),
      .bypass_A(ctl1[1]), .bypass_B(ctl1[0]), .out_valid(out_valid1),
      .out_ready(out_ready1), .out(out1), .err(err1), .err_cnt(err_cnt1), .leds(leds1));

   // scoreboard monitors: compare on each handshake that completes at the next edge
   always @(negedge clk) begin
      if (rst && out_valid0 && out_ready0) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL sb0 unexpected result err/out=%b, nothing expected", {err0, out0});
         end else begin
            logic [6:0] e;
            e = q0.pop_front();
            if ({err0, out0} !== e) begin
               errors++;
               $display("FAIL sb0 err/out got %b expected %b", {err0, out0}, e);
            end
         end
      end
      if (rst && out_valid1 && out_ready1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1 unexpected result err/out=%h, nothing expected", {err1, out1});
         end else begin
            logic [16:0] e;
            e = q1.pop_front();
            if ({err1, out1} !== e) begin
               errors++;
               $display("FAIL sb1 err/out got %h expected %h", {err1, out1}, e);
            end
         end
      end
   end

   // Drives one bundle from posedge+1, returns at posedge+1 after it is captured.
   task automatic send0(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                        input logic [6:0] ctl, input logic [6:0] exp_res);
      logic acc;
      int   n;
      a0 = a; b0 = b; op0 = op; ctl0 = ctl; in_valid0 = 1'b1;
      q0.push_back(exp_res);
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready0;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      in_valid0 = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept0 timeout in_ready got 0 expected 1");
      end
   endtask

   task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [6:0] ctl, input logic [16:0] exp_res);
      logic acc;
      int   n;
      a1 = a; b1 = b; op1 = op; ctl1 = ctl; in_valid1 = 1'b1;
      q1.push_back(exp_res);
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready1;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      in_valid1 = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept1 timeout in_ready got 0 expected 1");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain outstanding got %0d/%0d expected 0/0", q0.size(), q1.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid0 = 0; a0 = 0; b0 = 0; op0 = 0; ctl0 = NONE; out_ready0 = 1;
      in_valid1 = 0; a1 = 0; b1 = 0; op1 = 0; ctl1 = NONE; out_ready1 = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out0, out_valid0, err0, err_cnt0, leds0} !== '0) begin
         errors++;
         $display("FAIL reset0 outputs got %h expected 0", {out0, out_valid0, err0, err_cnt0, leds0});
      end
      checks++;
      if ({out1, out_valid1, err1, err_cnt1, leds1} !== '0) begin
         errors++;
         $display("FAIL reset1 outputs got %h expected 0", {out1, out_valid1, err1, err_cnt1, leds1});
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b%b expected 11", in_ready0, in_ready1);
      end
      // fill both stages, then reset between edges: everything clears, nothing emerges
      out_ready0 = 0;
      send0(3'b101, 3'b110, 3'b000, NONE, 7'b0_000100);
      send0(3'b011, 3'b110, 3'b001, NONE, 7'b0_000101);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({out0, out_valid0, err0, err_cnt0, leds0} !== '0) begin
         errors++;
         $display("FAIL reset_async outputs got %h expected 0", {out0, out_valid0, err0, err_cnt0, leds0});
      end
      q0.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      out_ready0 = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard out_valid got %b expected 0", out_valid0);
         end
      end
   endtask

   task automatic test_latency();
      send0(3'b101, 3'b110, 3'b000, NONE, 7'b0_000100);
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL lat_capture out_valid got %b expected 0", out_valid0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid0 !== 1'b1 || out0 !== 6'b000100) begin
         errors++;
         $display("FAIL lat_result valid/out got %b/%b expected 1/000100", out_valid0, out0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL lat_oneshot out_valid got %b expected 0", out_valid0);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      send0(3'b001, 3'b010, 3'b010, CIN,        7'b0_000100);
      send0(3'b010, 3'b011, 3'b011, NONE,       7'b0_000110);
      send0(3'b000, 3'b000, 3'b100, SIN | LEFT, 7'b0_001101);
      send0(3'b000, 3'b000, 3'b101, NONE,       7'b0_100110);
      drain();
   endtask

   task automatic test_backpressure();
      out_ready0 = 0;
      send0(3'b011, 3'b101, 3'b001, NONE, 7'b0_000110);
      send0(3'b111, 3'b011, 3'b000, NONE, 7'b0_000011);
      a0 = 3'b011; b0 = 3'b100; op0 = 3'b010; ctl0 = NONE; in_valid0 = 1'b1;
      q0.push_back(7'b0_000111);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out0 !== 6'b000110) begin
            errors++;
            $display("FAIL bp_hold ready/valid/out got %b/%b/%b expected 0/1/000110",
                     in_ready0, out_valid0, out0);
         end
         @(posedge clk);
         #1;
      end
      out_ready0 = 1;
      @(negedge clk);
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL bp_release in_ready got %b expected 1", in_ready0);
      end
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      drain();
   endtask

   task automatic test_invalid();
      send0(3'b101, 3'b110, 3'b111, NONE, 7'b1_000000);
      @(posedge clk);
      #1;
      checks++;
      if (err0 !== 1'b1 || err_cnt0 !== 8'd1 || leds0 !== 16'h0000) begin
         errors++;
         $display("FAIL inv_first err/cnt/leds got %b/%0d/%h expected 1/1/0000", err0, err_cnt0, leds0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (leds0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL inv_blink_on leds got %h expected FFFF", leds0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (leds0 !== 16'h0000) begin
         errors++;
         $display("FAIL inv_blink_off leds got %h expected 0000", leds0);
      end
      send0(3'b001, 3'b001, 3'b010, RA, 7'b1_000000);
      @(posedge clk);
      #1;
      checks++;
      if (err0 !== 1'b1 || err_cnt0 !== 8'd2) begin
         errors++;
         $display("FAIL inv_red err/cnt got %b/%0d expected 1/2", err0, err_cnt0);
      end
      send0(3'b101, 3'b110, 3'b001, NONE, 7'b0_000011);
      @(posedge clk);
      #1;
      checks++;
      if (err0 !== 1'b0 || leds0 !== 16'h0000 || err_cnt0 !== 8'd2) begin
         errors++;
         $display("FAIL inv_clear err/leds/cnt got %b/%h/%0d expected 0/0000/2", err0, leds0, err_cnt0);
      end
      drain();
   endtask

   task automatic test_priority();
      send0(3'b101, 3'b110, 3'b000, BA | BB, 7'b0_000101);
      send0(3'b111, 3'b000, 3'b000, RA | RB, 7'b0_000001);
      send0(3'b101, 3'b110, 3'b110, BA,      7'b1_000000);
      send0(3'b000, 3'b100, 3'b001, RB,      7'b0_000001);
      send1(8'h05, 8'h06, 3'b000, BA | BB, 17'h0_0006);
      send1(8'hFF, 8'h0F, 3'b000, RA | RB, 17'h0_0000);
      send1(8'hFF, 8'h0F, 3'b000, RA,      17'h0_0001);
      drain();
   endtask

   task automatic test_wide_and_saturation();
      send1(8'hFF, 8'hFF, 3'b011, NONE, 17'h0_FE01);
      send1(8'hFF, 8'h01, 3'b010, CIN,  17'h0_0100);
      for (int i = 0; i < 5; i++) begin
         send1(8'h12, 8'h34, 3'b110, NONE, 17'h1_0000);
         @(posedge clk);
         #1;
         checks++;
         if (err_cnt1 !== ((i < 3) ? 2'(i + 1) : 2'b11)) begin
            errors++;
            $display("FAIL sat_cnt step %0d got %0d expected %0d", i, err_cnt1, (i < 3) ? i + 1 : 3);
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_invalid();
      test_priority();
      test_wide_and_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout expected completion");
      $fatal(1);
   end

endmodule
